// File: rtl/sdio_serial_pkg.sv
// ---------------------------------------------------------------------------
// sdio_serial_pkg
// Shared definitions for the sdio serial transmitter slice:
//   - default word width / FIFO depth
//   - line level driven while the transmitter is idle
//   - FSM state encodings and the state enum built from them
// ---------------------------------------------------------------------------
package sdio_serial_pkg;

    localparam int   DEFAULT_WIDTH = 8;
    localparam int   DEFAULT_DEPTH = 4;

    // Level the data line is parked at when nothing is being driven.
    localparam logic IDLE_LEVEL    = 1'b0;

    // Fixed state encodings so existing debug tooling keeps decoding them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MARK = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MARK = ST_MARK,
        DATA = ST_DATA
    } state_t;

endpackage

// File: rtl/sdio_sync_fifo.sv
// ---------------------------------------------------------------------------
// sdio_sync_fifo
// Single-clock FIFO, WIDTH x DEPTH (DEPTH a power of two, >= 2).
// full/empty are registered, so a written word is first visible to the
// reader on the cycle after the write. Writes while full are dropped, even
// when a read happens in the same cycle. Synchronous reset flushes the FIFO.
//
// Ports:
//   sclk     in   clock
//   rst      in   synchronous active-high reset (flush)
//   wr_en    in   write request
//   wr_data  in   WIDTH  write word
//   rd_en    in   read (pop) request
//   rd_data  out  WIDTH  head of FIFO (valid when !empty)
//   full     out  registered full flag
//   empty    out  registered empty flag
// ---------------------------------------------------------------------------
module sdio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             push;
    logic             pop;

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + 1'b1;
        end else if (pop && !push) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    assign rd_data = mem[rptr];

endmodule

// File: rtl/sdio_serial_driver.sv
// ---------------------------------------------------------------------------
// sdio_serial_driver
// Serial transmitter for the single-wire sdio data line. Parallel words are
// accepted on a valid/ready interface, buffered in a small FIFO and shifted
// out MSB-first, one bit per sclk cycle. In marked format every data bit is
// preceded by a '1' marker bit. The line is parked at 0 with sdio_oe low
// when idle.
//
// Ports:
//   sclk         in   bus clock, all state changes on posedge
//   rst          in   synchronous active-high reset
//   tx_data      in   WIDTH  word to transmit
//   tx_valid     in   tx_data valid
//   tx_ready     out  FIFO can accept (!full and not in reset)
//   marked_mode  in   0 = raw, 1 = marked; sampled at each word start
//   sdio         out  serial data, registered
//   sdio_oe      out  output enable, registered
//   busy         out  transmitting or FIFO non-empty
// ---------------------------------------------------------------------------
module sdio_serial_driver
    import sdio_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             marked_mode,
    output logic             sdio,
    output logic             sdio_oe,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_dec;
    logic             mode_q;
    logic             mode_n;
    logic             sdio_n;
    logic             oe_n;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_dout;

    assign tx_ready = !fifo_full && !rst;

    sdio_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sclk    (sclk),
        .rst     (rst),
        .wr_en   (tx_valid && tx_ready),
        .wr_data (tx_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A new word starts from IDLE, or straight after the last bit of the
    // current word so back-to-back words have no gap.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == DATA) && (cnt == '0)));

    assign busy = (state != IDLE) || !fifo_empty;

    // cnt always holds the index of the data bit currently (or next, in MARK)
    // on the line; it counts down from WIDTH-1 and is reloaded per word.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        mode_n  = mode_q;
        sdio_n  = sdio;
        oe_n    = sdio_oe;
        cnt_dec = cnt - 1'b1;

        case (state)
            IDLE: begin
                sdio_n = IDLE_LEVEL;
                oe_n   = 1'b0;
            end
            MARK: begin
                sdio_n  = sh[cnt];
                state_n = DATA;
            end
            DATA: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    sdio_n  = IDLE_LEVEL;
                    oe_n    = 1'b0;
                end else begin
                    cnt_n = cnt_dec;
                    if (mode_q) begin
                        sdio_n  = 1'b1;
                        state_n = MARK;
                    end else begin
                        sdio_n = sh[cnt_dec];
                    end
                end
            end
            default: begin
                state_n = IDLE;
                sdio_n  = IDLE_LEVEL;
                oe_n    = 1'b0;
            end
        endcase

        // Word start overrides the idle/end-of-word decisions above.
        if (fifo_pop) begin
            sh_n   = fifo_dout;
            cnt_n  = CNT_W'(WIDTH - 1);
            mode_n = marked_mode;
            oe_n   = 1'b1;
            if (marked_mode) begin
                sdio_n  = 1'b1;
                state_n = MARK;
            end else begin
                sdio_n  = fifo_dout[WIDTH-1];
                state_n = DATA;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            mode_q  <= 1'b0;
            sdio    <= IDLE_LEVEL;
            sdio_oe <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            cnt     <= cnt_n;
            mode_q  <= mode_n;
            sdio    <= sdio_n;
            sdio_oe <= oe_n;
        end
    end

endmodule

// File: tb/tb_sdio_serial_driver.sv
// ---------------------------------------------------------------------------
// tb_sdio_serial_driver
// Directed bench for sdio_serial_driver (WIDTH=8, DEPTH=4). Inputs are driven
// and outputs sampled 1 time unit after each rising edge of sclk.
// ---------------------------------------------------------------------------
module tb_sdio_serial_driver;

    logic       sclk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       marked_mode;
    logic       sdio;
    logic       sdio_oe;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    sdio_serial_driver #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .marked_mode (marked_mode),
        .sdio        (sdio),
        .sdio_oe     (sdio_oe),
        .busy        (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  a5;
        logic [15:0] m3c;
        logic [7:0]  w81;
        logic        exp_bit;
        int          pushed;
        int          j;
        logic        acc;

        a5  = 8'hA5;
        m3c = 16'b1010_1111_1111_1010;
        w81 = 8'h81;

        // ---------------- reset with tx_valid asserted ----------------
        rst         = 1'b1;
        tx_valid    = 1'b1;
        tx_data     = 8'hEE;
        marked_mode = 1'b0;
        step();
        chk("rst1_sdio",     sdio,     1'b0);
        chk("rst1_oe",       sdio_oe,  1'b0);
        chk("rst1_busy",     busy,     1'b0);
        chk("rst1_tx_ready", tx_ready, 1'b0);
        step();
        chk("rst2_sdio",     sdio,     1'b0);
        chk("rst2_oe",       sdio_oe,  1'b0);
        chk("rst2_busy",     busy,     1'b0);
        chk("rst2_tx_ready", tx_ready, 1'b0);
        rst      = 1'b0;
        tx_valid = 1'b0;
        #1;
        chk("rel_tx_ready",  tx_ready, 1'b1);
        step();
        chk("rel_busy",      busy,     1'b0);
        chk("rel_oe",        sdio_oe,  1'b0);
        step();

        // ---------------- raw 0xA5 ----------------
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        step();                         // edge 0: push
        tx_valid = 1'b0;
        chk("a5_lat_oe",   sdio_oe, 1'b0);
        chk("a5_lat_busy", busy,    1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("a5_bit%0d", k), sdio,    a5[8-k]);
            chk($sformatf("a5_oe%0d", k),  sdio_oe, 1'b1);
        end
        step();                         // edge 9
        chk("a5_end_sdio", sdio,    1'b0);
        chk("a5_end_oe",   sdio_oe, 1'b0);
        chk("a5_end_busy", busy,    1'b0);
        step();

        // ---------------- marked 0x3C ----------------
        marked_mode = 1'b1;
        tx_data     = 8'h3C;
        tx_valid    = 1'b1;
        step();                         // edge 0: push
        tx_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("m3c_bit%0d", k), sdio,    m3c[16-k]);
            chk($sformatf("m3c_oe%0d", k),  sdio_oe, 1'b1);
        end
        step();
        chk("m3c_end_sdio", sdio,    1'b0);
        chk("m3c_end_oe",   sdio_oe, 1'b0);
        chk("m3c_end_busy", busy,    1'b0);
        marked_mode = 1'b0;
        step();

        // ---------------- back-to-back raw 0x01..0x06 ----------------
        pushed = 0;
        for (int k = 0; k <= 49; k++) begin
            tx_valid = (pushed < 6);
            tx_data  = 8'(pushed + 1);
            #1;
            acc = tx_valid && tx_ready;
            step();                     // edge k
            if (acc) pushed++;
            if (k == 4) chk("b2b_full_e4", tx_ready, 1'b0);
            if (k == 8) chk("b2b_full_e8", tx_ready, 1'b0);
            if (k == 9) chk("b2b_rerise_e9", tx_ready, 1'b1);
            if (k >= 1 && k <= 48) begin
                j       = (k - 1) / 8;
                exp_bit = ((j + 1) >> (7 - ((k - 1) % 8))) & 1;
                chk($sformatf("b2b_bit%0d", k), sdio,    exp_bit);
                chk($sformatf("b2b_oe%0d", k),  sdio_oe, 1'b1);
            end
            if (k == 49) begin
                chk("b2b_end_oe",   sdio_oe, 1'b0);
                chk("b2b_end_sdio", sdio,    1'b0);
                chk("b2b_end_busy", busy,    1'b0);
            end
        end
        tx_valid = 1'b0;
        chk("b2b_pushed", pushed, 6);
        step();

        // ---------------- reset mid-word ----------------
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        step();                         // edge 0: push 0xFF
        tx_data = 8'h11;
        step();                         // edge 1: push 0x11, bit 7 out
        chk("mid_bit1", sdio, 1'b1);
        tx_data = 8'h22;
        step();                         // edge 2: push 0x22
        chk("mid_bit2", sdio, 1'b1);
        tx_valid = 1'b0;
        step();                         // edge 3
        chk("mid_bit3", sdio, 1'b1);
        rst = 1'b1;
        step();                         // edge 4: reset
        chk("mid_rst_sdio",  sdio,     1'b0);
        chk("mid_rst_oe",    sdio_oe,  1'b0);
        chk("mid_rst_busy",  busy,     1'b0);
        chk("mid_rst_ready", tx_ready, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("mid_after_oe%0d", k), sdio_oe, 1'b0);
            chk($sformatf("mid_after_sd%0d", k), sdio,    1'b0);
        end
        chk("mid_after_busy", busy, 1'b0);

        // ---------------- marked_mode toggled mid-word ----------------
        marked_mode = 1'b0;
        tx_data     = 8'h81;
        tx_valid    = 1'b1;
        step();                         // edge 0
        step();                         // edge 1: second push, word 1 starts
        tx_valid = 1'b0;
        chk("tog_bit1", sdio, 1'b1);
        chk("tog_oe1",  sdio_oe, 1'b1);
        for (int k = 2; k <= 24; k++) begin
            if (k == 4) marked_mode = 1'b1;
            step();
            if (k <= 8) begin
                exp_bit = w81[8-k];
            end else begin
                j = k - 9;
                exp_bit = ((j % 2) == 0) ? 1'b1 : w81[7 - j/2];
            end
            chk($sformatf("tog_bit%0d", k), sdio,    exp_bit);
            chk($sformatf("tog_oe%0d", k),  sdio_oe, 1'b1);
        end
        step();                         // edge 25
        chk("tog_end_sdio", sdio,    1'b0);
        chk("tog_end_oe",   sdio_oe, 1'b0);
        chk("tog_end_busy", busy,    1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
